pll_lock_seq: RTL and testbench
===============================

# pll_lock_seq

Power-up, lock-supervision and recovery sequencer for the system PLL.
- Runs on the PLL reference clock, since the PLL output is not trustworthy before lock.
- Drives the PLL reset and standby pins and supervises the asynchronous lock indication.
- Retries a failed lock a bounded number of times, then holds off a fault.
- Releases the downstream system reset only after lock has been stable; downstream logic re-synchronises `sys_rst_n` into its own domain.

## Interface
Parameters
- `RST_CYCLES`, default 16: width of the PLL reset pulse, in clk cycles.
- `LOCK_TIMEOUT`, default 50000: cycles allowed in WAIT_LOCK (1 ms at 50 MHz).
- `LOCK_STABLE`, default 1024: cycles of continuous lock required before release.
- `MAX_RETRY`, default 3: consecutive lock timeouts tolerated before FAULT.
- `PS_SETTLE`, default 4: wait after each phase-control pulse.

Ports
- One clock; reset is asynchronous and active-low.
- `clk` in 1: PLL reference clock, same net as the PLL input clock.
- `rst_n` in 1: asynchronous active-low reset.
- `enable` in 1: level; 1 = run the PLL, 0 = standby.
- `pll_lock` in 1: raw, asynchronous PLL lock.
- `pll_rst` out 1: PLL RST.
- `pll_stdby` out 1: PLL USRSTDBY.
- `sys_rst_n` out 1: downstream reset, active-low.
- `locked` out 1: PLL locked and released.
- `fault` out 1: sticky; retries exhausted.
- `lol_count` out 8: loss-of-lock events in RUN, saturating at 255.
- `retry_count` out 4: consecutive lock timeouts.
- Phase ports, present only with `PLL_PHASE_STEP_EN`:
  - `ps_req` in 1
  - `ps_sel` in 2
  - `ps_dir` in 1
  - `ps_ack` out 1
  - `pll_phasesel` out 2
  - `pll_phasedir` out 1
  - `pll_phasestep` out 1
  - `pll_phaseloadreg` out 1

## Operation
`pll_lock` passes through a 2-flop synchroniser; the synchronised value is `lock_s`. One shared cycle counter serves all states and clears on every state change.

States
- **IDLE** (reset state): `pll_rst`=1. Leaves to RESET when `enable`=1.
- **RESET**: `pll_rst`=1 for exactly `RST_CYCLES` cycles, then WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst`=0.
  - `lock_s`=1: go to STABLE.
  - Counter reaches `LOCK_TIMEOUT-1`: `retry_count`++. If `retry_count` now equals `MAX_RETRY`, go to FAULT; otherwise go to RESET.
- **STABLE**: needs `LOCK_STABLE` consecutive cycles of `lock_s`=1.
  - `lock_s` drops: back to WAIT_LOCK with a fresh timeout; this is not a retry.
  - Completion: go to RUN, clear `retry_count`.
- **RUN**: `locked`=1, `sys_rst_n`=1. Priority each cycle:
  1. `lock_s`=0: `lol_count`++ (saturating), go to RESET.
  2. `enable`=0: go to STDBY.
  3. `ps_req`=1 (macro only): go to PHASE.
- **STDBY**: `pll_stdby`=1, `pll_rst`=0. Leaves to RESET when `enable`=1.
- **FAULT**: `pll_rst`=1, `fault`=1. Leaves only on `enable`=0, to IDLE; the exit clears `fault` and `retry_count`.
- **PHASE** (macro only): sequence below.
- `enable`=0 in RESET, WAIT_LOCK or STABLE: go to STDBY immediately.

Outputs by state
- `locked`=1 and `sys_rst_n`=1 only in RUN and PHASE.
- `pll_stdby`=1 only in STDBY.
- `lol_count` is cleared only by `rst_n`.

## Timing
- All outputs are registered.
- Reset values: `pll_rst`=1, `pll_stdby`=0, `sys_rst_n`=0, `locked`=0, `fault`=0, counts 0, all phase outputs 0.
- Latency from a `pll_lock` edge to `lock_s` is 2 cycles; the dependent outputs change on the following edge (3 cycles total).
- Minimum from `enable` rise to `sys_rst_n`=1: `RST_CYCLES` + 3 + `LOCK_STABLE` cycles.
- `rst_n` asserted mid-sequence: all outputs return to reset values immediately; the PLL is reset again on restart.
- A loss of lock in the same cycle as `ps_req`: the loss of lock wins and the request is not accepted.

## Configuration
Macro: `PLL_PHASE_STEP_EN`.
- Defined: phase ports and the PHASE state are present.
  - On entry, latch `ps_sel` and `ps_dir` onto `pll_phasesel` and `pll_phasedir`.
  - 1 setup cycle.
  - `pll_phasestep`=1 for 1 cycle, then wait `PS_SETTLE` cycles.
  - `pll_phaseloadreg`=1 for 1 cycle, then wait `PS_SETTLE` cycles.
  - `ps_ack`=1 for 1 cycle, return to RUN.
  - `ps_req` must be held until `ps_ack`; a new request is accepted no earlier than the cycle after `ps_ack`.
  - Loss of lock during PHASE aborts the sequence with no `ps_ack` and goes to RESET.
- Undefined: the phase ports are absent and the PLL phase pins are tied low at the top level.

## Structure
- Package `pll_ctrl_pkg` holds:
  - the state enum;
  - the counter width `CNT_W` = clog2 of the maximum of the parameters;
  - the `lol_count` saturation constant.
- Sub-module `sync_2ff` provides the lock synchroniser.
- Everything else is a single FSM plus the shared counter.

## Test plan
Bench parameters: `RST_CYCLES`=4, `LOCK_TIMEOUT`=20, `LOCK_STABLE`=8, `MAX_RETRY`=2.
- **Clean lock**: `enable`=1; `pll_lock`=1 from cycle 10 → `pll_rst` high 4 cycles; `sys_rst_n` and `locked` rise exactly 8 cycles after `lock_s`.
- **Lock glitch in STABLE**: `pll_lock` low 1 cycle midway → stable count restarts; `retry_count` stays 0.
- **Retry exhaustion**: `pll_lock` held 0 → 2 timeouts of 20 cycles each → `fault`=1 with `pll_rst`=1; `enable`=0 → IDLE, `fault`=0.
- **Loss of lock in RUN**: drop `pll_lock` → 3 cycles later `locked`=0 and `sys_rst_n`=0; `lol_count`=1; relock follows. After 256 forced losses, `lol_count` reads 255.
- **Standby**: `enable`=0 in RUN → `pll_stdby`=1, `sys_rst_n`=0; `enable`=1 → RESET, then relock.
- **Phase step** (macro defined): `ps_req` with `ps_sel`=2, `ps_dir`=1 → pulses on `pll_phasestep`, then `pll_phaseloadreg` 5 cycles later, then `ps_ack` 5 cycles after that; loss of lock mid-sequence → no `ps_ack`.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types and constants for the PLL lock sequencer.
//   pll_state_e : sequencer state encoding
//   cnt_width() : width needed by the shared cycle counter for a parameter set
//   CNT_W       : counter width for the default parameter set
//   LOL_MAX     : saturation value of the loss-of-lock counter
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StWaitLock,
        StStable,
        StRun,
        StStdby,
        StFault,
        StPhase
    } pll_state_e;

    localparam int unsigned DEF_RST_CYCLES   = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT = 50000;
    localparam int unsigned DEF_LOCK_STABLE  = 1024;
    localparam int unsigned DEF_PS_SETTLE    = 4;

    localparam logic [7:0] LOL_MAX = 8'hFF;

    // Width that can hold the largest terminal count of any state.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(DEF_RST_CYCLES, DEF_LOCK_TIMEOUT,
                                              DEF_LOCK_STABLE, 2 * DEF_PS_SETTLE + 4);

endpackage

// File: rtl/pll_lock_seq_if.sv
// pll_lock_seq_if: signal bundle between the PLL lock sequencer and its surroundings.
//   enable, pll_lock                  : control level and raw PLL lock into the sequencer
//   pll_rst, pll_stdby                : PLL reset / standby pins
//   sys_rst_n, locked, fault          : downstream reset and status
//   lol_count, retry_count            : loss-of-lock and consecutive-timeout counters
//   pll_phasesel/dir/step/loadreg     : PLL phase pins (tied low unless PLL_PHASE_STEP_EN)
//   ps_req, ps_sel, ps_dir, ps_ack    : phase-step handshake, only with PLL_PHASE_STEP_EN
// modport master: the sequencer; modport slave: the system / PLL side.
interface pll_lock_seq_if;

    logic       enable;
    logic       pll_lock;
    logic       pll_rst;
    logic       pll_stdby;
    logic       sys_rst_n;
    logic       locked;
    logic       fault;
    logic [7:0] lol_count;
    logic [3:0] retry_count;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir;
    logic       pll_phasestep;
    logic       pll_phaseloadreg;
`ifdef PLL_PHASE_STEP_EN
    logic       ps_req;
    logic [1:0] ps_sel;
    logic       ps_dir;
    logic       ps_ack;

    modport master (
        input  enable, pll_lock, ps_req, ps_sel, ps_dir,
        output pll_rst, pll_stdby, sys_rst_n, locked, fault, lol_count, retry_count,
        output pll_phasesel, pll_phasedir, pll_phasestep, pll_phaseloadreg, ps_ack
    );

    modport slave (
        output enable, pll_lock, ps_req, ps_sel, ps_dir,
        input  pll_rst, pll_stdby, sys_rst_n, locked, fault, lol_count, retry_count,
        input  pll_phasesel, pll_phasedir, pll_phasestep, pll_phaseloadreg, ps_ack
    );
`else
    modport master (
        input  enable, pll_lock,
        output pll_rst, pll_stdby, sys_rst_n, locked, fault, lol_count, retry_count,
        output pll_phasesel, pll_phasedir, pll_phasestep, pll_phaseloadreg
    );

    modport slave (
        output enable, pll_lock,
        input  pll_rst, pll_stdby, sys_rst_n, locked, fault, lol_count, retry_count,
        input  pll_phasesel, pll_phasedir, pll_phasestep, pll_phaseloadreg
    );
`endif

endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level.
//   clk, rst_n : clock and asynchronous active-low reset (output resets to 0)
//   d          : asynchronous input
//   q          : input synchronised to clk, two cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_seq.sv
// pll_lock_seq: power-up, lock-supervision and recovery sequencer for the system PLL.
// Runs on the PLL reference clock.
//   clk   : PLL reference clock
//   rst_n : asynchronous active-low reset
//   bus   : pll_lock_seq_if.master (control, PLL pins, status, counters)
// Optional feature macro PLL_PHASE_STEP_EN adds the phase-step handshake and PHASE state;
// without it the PLL phase pins are tied low.
module pll_lock_seq
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned PS_SETTLE    = 4
) (
    input logic          clk,
    input logic          rst_n,
    pll_lock_seq_if.master bus
);

    localparam int unsigned ParamW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE,
                                               2 * PS_SETTLE + 4);
    // Never narrower than the default build.
    localparam int unsigned CntW = (ParamW > CNT_W) ? ParamW : CNT_W;

    localparam logic [CntW-1:0] RstLast     = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that sees lock_s=1 is the first stable cycle, so STABLE
    // itself spans LOCK_STABLE-1 cycles.
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE - 2);
    localparam logic [3:0]      RetryMax    = 4'(MAX_RETRY);

    logic            lock_s;
    pll_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      retry_q;
    logic [7:0]      lol_q;
    logic            retry_inc, retry_clr, lol_inc;
    logic            pll_rst_q, pll_stdby_q, sys_rst_n_q, locked_q, fault_q;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

`ifdef PLL_PHASE_STEP_EN
    localparam logic [CntW-1:0] StepAt    = '0;
    localparam logic [CntW-1:0] LoadAt    = CntW'(PS_SETTLE + 1);
    localparam logic [CntW-1:0] AckAt     = CntW'(2 * PS_SETTLE + 2);
    localparam logic [CntW-1:0] PhaseLast = CntW'(2 * PS_SETTLE + 3);

    logic       phase_hold;
    logic [1:0] phasesel_q;
    logic       phasedir_q, phasestep_q, loadreg_q, ps_ack_q;

    // Staying in PHASE; an abort to RESET suppresses any pending pulse.
    assign phase_hold = (state_q == StPhase) && (state_d == StPhase);
`endif

    always_comb begin
        state_d   = state_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        lol_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.enable) state_d = StReset;
            end
            StReset: begin
                if (!bus.enable)           state_d = StStdby;
                else if (cnt_q == RstLast) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (!bus.enable) begin
                    state_d = StStdby;
                end else if (lock_s) begin
                    state_d = StStable;
                end else if (cnt_q == TimeoutLast) begin
                    retry_inc = 1'b1;
                    state_d   = (retry_q + 4'd1 == RetryMax) ? StFault : StReset;
                end
            end
            StStable: begin
                if (!bus.enable) begin
                    state_d = StStdby;
                end else if (!lock_s) begin
                    state_d = StWaitLock;
                end else if (cnt_q == StableLast) begin
                    state_d   = StRun;
                    retry_clr = 1'b1;
                end
            end
            StRun: begin
                if (!lock_s) begin
                    lol_inc = 1'b1;
                    state_d = StReset;
                end else if (!bus.enable) begin
                    state_d = StStdby;
                end
`ifdef PLL_PHASE_STEP_EN
                else if (bus.ps_req) begin
                    state_d = StPhase;
                end
`endif
            end
            StStdby: begin
                if (bus.enable) state_d = StReset;
            end
            StFault: begin
                if (!bus.enable) begin
                    state_d   = StIdle;
                    retry_clr = 1'b1;
                end
            end
`ifdef PLL_PHASE_STEP_EN
            StPhase: begin
                // PHASE is part of the locked period, so a drop counts as a loss of lock.
                if (!lock_s) begin
                    lol_inc = 1'b1;
                    state_d = StReset;
                end else if (cnt_q == PhaseLast) begin
                    state_d = StRun;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            retry_q     <= '0;
            lol_q       <= '0;
            pll_rst_q   <= 1'b1;
            pll_stdby_q <= 1'b0;
            sys_rst_n_q <= 1'b0;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
`ifdef PLL_PHASE_STEP_EN
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
            loadreg_q   <= 1'b0;
            ps_ack_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
            pll_rst_q   <= (state_d == StIdle) || (state_d == StReset) || (state_d == StFault);
            pll_stdby_q <= (state_d == StStdby);
            sys_rst_n_q <= (state_d == StRun) || (state_d == StPhase);
            locked_q    <= (state_d == StRun) || (state_d == StPhase);
            fault_q     <= (state_d == StFault);
            if (retry_clr)      retry_q <= '0;
            else if (retry_inc) retry_q <= retry_q + 4'd1;
            if (lol_inc && (lol_q != LOL_MAX)) lol_q <= lol_q + 8'd1;
`ifdef PLL_PHASE_STEP_EN
            if ((state_q == StRun) && (state_d == StPhase)) begin
                phasesel_q <= bus.ps_sel;
                phasedir_q <= bus.ps_dir;
            end
            phasestep_q <= phase_hold && (cnt_q == StepAt);
            loadreg_q   <= phase_hold && (cnt_q == LoadAt);
            ps_ack_q    <= phase_hold && (cnt_q == AckAt);
`endif
        end
    end

    assign bus.pll_rst     = pll_rst_q;
    assign bus.pll_stdby   = pll_stdby_q;
    assign bus.sys_rst_n   = sys_rst_n_q;
    assign bus.locked      = locked_q;
    assign bus.fault       = fault_q;
    assign bus.lol_count   = lol_q;
    assign bus.retry_count = retry_q;

`ifdef PLL_PHASE_STEP_EN
    assign bus.pll_phasesel     = phasesel_q;
    assign bus.pll_phasedir     = phasedir_q;
    assign bus.pll_phasestep    = phasestep_q;
    assign bus.pll_phaseloadreg = loadreg_q;
    assign bus.ps_ack           = ps_ack_q;
`else
    assign bus.pll_phasesel     = 2'b00;
    assign bus.pll_phasedir     = 1'b0;
    assign bus.pll_phasestep    = 1'b0;
    assign bus.pll_phaseloadreg = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: self-checking bench for pll_lock_seq with a timed-expectation scoreboard.
// Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2, PS_SETTLE=4.
module tb_pll_lock_seq;

    localparam int SigPllRst   = 0;
    localparam int SigStdby    = 1;
    localparam int SigSysRstN  = 2;
    localparam int SigLocked   = 3;
    localparam int SigFault    = 4;
    localparam int SigLol      = 5;
    localparam int SigRetry    = 6;
    localparam int SigStep     = 7;
    localparam int SigLoad     = 8;
    localparam int SigAck      = 9;
    localparam int SigPhaseSel = 10;
    localparam int SigPhaseDir = 11;

    typedef struct packed {
        int          cyc;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    pll_lock_seq_if bus ();

    pll_lock_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .LOCK_STABLE  (8),
        .MAX_RETRY    (2),
        .PS_SETTLE    (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_sig(input int sig);
        case (sig)
            SigPllRst:   return 32'(bus.pll_rst);
            SigStdby:    return 32'(bus.pll_stdby);
            SigSysRstN:  return 32'(bus.sys_rst_n);
            SigLocked:   return 32'(bus.locked);
            SigFault:    return 32'(bus.fault);
            SigLol:      return 32'(bus.lol_count);
            SigRetry:    return 32'(bus.retry_count);
            SigStep:     return 32'(bus.pll_phasestep);
            SigLoad:     return 32'(bus.pll_phaseloadreg);
`ifdef PLL_PHASE_STEP_EN
            SigAck:      return 32'(bus.ps_ack);
`endif
            SigPhaseSel: return 32'(bus.pll_phasesel);
            SigPhaseDir: return 32'(bus.pll_phasedir);
            default:     return 32'hDEAD;
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            SigPllRst:   return "pll_rst";
            SigStdby:    return "pll_stdby";
            SigSysRstN:  return "sys_rst_n";
            SigLocked:   return "locked";
            SigFault:    return "fault";
            SigLol:      return "lol_count";
            SigRetry:    return "retry_count";
            SigStep:     return "pll_phasestep";
            SigLoad:     return "pll_phaseloadreg";
            SigAck:      return "ps_ack";
            SigPhaseSel: return "pll_phasesel";
            SigPhaseDir: return "pll_phasedir";
            default:     return "unknown";
        endcase
    endfunction

    // Expect signal 'sig' to read 'v' once 'd' more rising edges have passed.
    task automatic expect_at(input int d, input int sig, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc + d;
        e.sig = sig;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    // Compare due expectations on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    check_eq($sformatf("%s@%0d", sig_name(sb_q[i].sig), cyc),
                             get_sig(sb_q[i].sig), sb_q[i].exp);
                    sb_q.delete(i);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_locked(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (bus.locked !== 1'b1 && n < max_cyc) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(bus.locked), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.pll_lock = 1'b0;
`ifdef PLL_PHASE_STEP_EN
        bus.ps_req = 1'b0;
        bus.ps_sel = 2'd0;
        bus.ps_dir = 1'b0;
`endif
        #23;
        check_eq("rst_pll_rst",   32'(bus.pll_rst), 32'd1);
        check_eq("rst_pll_stdby", 32'(bus.pll_stdby), 32'd0);
        check_eq("rst_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
        check_eq("rst_locked",    32'(bus.locked), 32'd0);
        check_eq("rst_fault",     32'(bus.fault), 32'd0);
        check_eq("rst_lol",       32'(bus.lol_count), 32'd0);
        check_eq("rst_retry",     32'(bus.retry_count), 32'd0);
        check_eq("rst_phase",     32'({bus.pll_phasesel, bus.pll_phasedir,
                                       bus.pll_phasestep, bus.pll_phaseloadreg}), 32'd0);
        rst_n = 1'b1;
        step(3);
        check_eq("idle_pll_rst", 32'(bus.pll_rst), 32'd1);

        // Clean lock: lock arrives 10 cycles after enable.
        for (int d = 1; d <= 4; d++) expect_at(d, SigPllRst, 1);
        expect_at(5, SigPllRst, 0);
        expect_at(19, SigSysRstN, 0);
        expect_at(19, SigLocked, 0);
        expect_at(20, SigSysRstN, 1);
        expect_at(20, SigLocked, 1);
        expect_at(20, SigRetry, 0);
        expect_at(20, SigStdby, 0);
        bus.enable = 1'b1;
        step(10);
        bus.pll_lock = 1'b1;
        step(11);

        // Loss of lock in RUN, relock with a one-cycle glitch during STABLE.
        expect_at(2, SigLocked, 1);
        expect_at(3, SigLocked, 0);
        expect_at(3, SigSysRstN, 0);
        expect_at(3, SigPllRst, 1);
        expect_at(3, SigLol, 1);
        expect_at(7, SigPllRst, 0);
        expect_at(13, SigPllRst, 0);
        expect_at(15, SigLocked, 0);
        expect_at(20, SigLocked, 0);
        expect_at(21, SigLocked, 1);
        expect_at(21, SigSysRstN, 1);
        expect_at(21, SigRetry, 0);
        bus.pll_lock = 1'b0;
        step(3);
        bus.pll_lock = 1'b1;
        step(7);
        bus.pll_lock = 1'b0;
        step(1);
        bus.pll_lock = 1'b1;
        step(11);

        // Standby from RUN and back.
        expect_at(0, SigLocked, 1);
        expect_at(1, SigStdby, 1);
        expect_at(1, SigSysRstN, 0);
        expect_at(1, SigLocked, 0);
        expect_at(1, SigPllRst, 0);
        expect_at(5, SigStdby, 1);
        expect_at(6, SigStdby, 0);
        expect_at(6, SigPllRst, 1);
        expect_at(10, SigPllRst, 0);
        expect_at(17, SigSysRstN, 0);
        expect_at(18, SigSysRstN, 1);
        bus.enable = 1'b0;
        step(5);
        bus.enable = 1'b1;
        step(14);

        // Retry exhaustion: lock lost in RUN and never returns.
        expect_at(3, SigLol, 2);
        expect_at(3, SigPllRst, 1);
        expect_at(7, SigPllRst, 0);
        expect_at(26, SigRetry, 0);
        expect_at(27, SigRetry, 1);
        expect_at(27, SigPllRst, 1);
        expect_at(31, SigPllRst, 0);
        expect_at(50, SigFault, 0);
        expect_at(51, SigFault, 1);
        expect_at(51, SigRetry, 2);
        expect_at(51, SigPllRst, 1);
        expect_at(55, SigFault, 1);
        expect_at(56, SigFault, 0);
        expect_at(56, SigRetry, 0);
        expect_at(56, SigPllRst, 1);
        expect_at(56, SigLocked, 0);
        bus.pll_lock = 1'b0;
        step(55);
        bus.enable = 1'b0;
        step(2);

        // Repeated losses until lol_count saturates.
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        wait_locked(60, "relock_after_fault");
        for (int i = 3; i <= 256; i++) begin
            expect_at(3, SigLol, (i > 255) ? 32'd255 : 32'(i));
            bus.pll_lock = 1'b0;
            step(3);
            bus.pll_lock = 1'b1;
            wait_locked(40, "relock_loop");
        end
        check_eq("lol_saturated", 32'(bus.lol_count), 32'd255);

        // Reset asserted mid-sequence (in STABLE).
        bus.pll_lock = 1'b0;
        step(3);
        bus.pll_lock = 1'b1;
        step(6);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_pll_rst", 32'(bus.pll_rst), 32'd1);
        check_eq("midrst_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
        check_eq("midrst_locked", 32'(bus.locked), 32'd0);
        check_eq("midrst_lol", 32'(bus.lol_count), 32'd0);
        step(2);
        rst_n = 1'b1;
        expect_at(4, SigPllRst, 1);
        expect_at(5, SigPllRst, 0);
        expect_at(12, SigLocked, 0);
        expect_at(13, SigLocked, 1);
        expect_at(13, SigLol, 0);
        step(14);

`ifdef PLL_PHASE_STEP_EN
        // Full phase-step sequence.
        expect_at(1, SigPhaseSel, 2);
        expect_at(1, SigPhaseDir, 1);
        expect_at(1, SigLocked, 1);
        expect_at(1, SigStep, 0);
        expect_at(2, SigStep, 1);
        expect_at(3, SigStep, 0);
        expect_at(6, SigLoad, 0);
        expect_at(7, SigLoad, 1);
        expect_at(8, SigLoad, 0);
        expect_at(11, SigAck, 0);
        expect_at(12, SigAck, 1);
        expect_at(13, SigAck, 0);
        bus.ps_sel = 2'd2;
        bus.ps_dir = 1'b1;
        bus.ps_req = 1'b1;
        step(12);
        bus.ps_req = 1'b0;
        step(3);

        // Loss of lock mid-sequence aborts without an ack.
        expect_at(1, SigPhaseSel, 1);
        expect_at(2, SigStep, 1);
        expect_at(7, SigLocked, 0);
        expect_at(7, SigLoad, 0);
        expect_at(7, SigPllRst, 1);
        expect_at(7, SigAck, 0);
        expect_at(12, SigAck, 0);
        bus.ps_sel = 2'd1;
        bus.ps_dir = 1'b0;
        bus.ps_req = 1'b1;
        step(4);
        bus.pll_lock = 1'b0;
        step(3);
        bus.ps_req   = 1'b0;
        bus.pll_lock = 1'b1;
        step(8);
        wait_locked(40, "relock_after_phase_abort");
`endif

        step(2);
        check_eq("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
